// File: rtl/uart_rx_frame_timer_pkg.sv
// Shared constants and frame-length helper for the UART RX timing engine.
package uart_rx_pkg;

    localparam int MIN_PRESCALE   = 4;
    localparam int FRAME_BITS_MAX = 12;
    localparam int DATA_LEN_MIN   = 5;
    localparam int DATA_LEN_MAX   = 8;

    // start + data + optional parity + one or two stop bits
    function automatic int frame_bits(input logic [3:0] data_len,
                                      input logic       par_en,
                                      input logic       stop2);
        return 1 + int'(data_len) + int'(par_en) + (stop2 ? 2 : 1);
    endfunction

endpackage

// File: rtl/uart_rx_frame_timer_if.sv
// Control/config inputs and timing outputs exchanged between the RX FSM and the frame timer.
interface uart_rx_frame_timer_if #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
);
    logic                  en;
    logic [PRESCALE_W-1:0] prescale;
    logic [3:0]            data_len;
    logic                  par_en;
    logic                  stop2;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  sample_stb;
    logic                  sample_last;
    logic                  bit_done;
    logic                  frame_done;
    logic                  cfg_err;

    modport master (
        output en, prescale, data_len, par_en, stop2,
        input  edge_cnt, bit_cnt, sample_stb, sample_last, bit_done, frame_done, cfg_err
    );

    modport slave (
        input  en, prescale, data_len, par_en, stop2,
        output edge_cnt, bit_cnt, sample_stb, sample_last, bit_done, frame_done, cfg_err
    );
endinterface

// File: rtl/uart_rx_frame_timer_cfg_shadow.sv
// Shadow copy of the frame configuration, tracking inputs while idle and frozen while counting.
module uart_rx_cfg_shadow #(
    parameter int PRESCALE_W   = 6,
    parameter int MIN_PRESCALE = uart_rx_pkg::MIN_PRESCALE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic [3:0]            i_data_len,
    input  logic                  i_par_en,
    input  logic                  i_stop2,
    output logic [PRESCALE_W-1:0] o_prescale,
    output logic [3:0]            o_data_len,
    output logic                  o_par_en,
    output logic                  o_stop2,
    output logic                  o_cfg_err
);
    import uart_rx_pkg::*;

    logic [PRESCALE_W-1:0] r_prescale;
    logic [3:0]            r_data_len;
    logic                  r_par_en;
    logic                  r_stop2;
    logic                  r_cfg_err;
    logic                  w_cfg_err_next;

    // Judged on the value being captured so the error flag always matches the shadow contents.
    assign w_cfg_err_next = (i_prescale < PRESCALE_W'(MIN_PRESCALE))
                          | (i_data_len < 4'(DATA_LEN_MIN))
                          | (i_data_len > 4'(DATA_LEN_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prescale <= '0;
            r_data_len <= '0;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_cfg_err  <= 1'b1;
        end else if (!i_en) begin
            r_prescale <= i_prescale;
            r_data_len <= i_data_len;
            r_par_en   <= i_par_en;
            r_stop2    <= i_stop2;
            r_cfg_err  <= w_cfg_err_next;
        end
    end

    assign o_prescale = r_prescale;
    assign o_data_len = r_data_len;
    assign o_par_en   = r_par_en;
    assign o_stop2    = r_stop2;
    assign o_cfg_err  = r_cfg_err;

endmodule

// File: rtl/uart_rx_frame_timer.sv
// Edge and bit counters for the UART RX path with mid-bit sample, bit-done and frame-done decodes.
module uart_rx_frame_timer #(
    parameter int PRESCALE_W   = 6,
    parameter int BIT_CNT_W    = 4,
    parameter int MIN_PRESCALE = uart_rx_pkg::MIN_PRESCALE
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_frame_timer_if.slave  bus
);
    import uart_rx_pkg::*;

    logic [PRESCALE_W-1:0] w_s_prescale;
    logic [3:0]            w_s_data_len;
    logic                  w_s_par_en;
    logic                  w_s_stop2;
    logic                  w_cfg_err;

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;

    logic                  w_run;
    logic [PRESCALE_W-1:0] w_mid;
    logic [BIT_CNT_W-1:0]  w_frame_last;
    logic                  w_edge_last;
    logic                  w_bit_last;

    uart_rx_cfg_shadow #(
        .PRESCALE_W   (PRESCALE_W),
        .MIN_PRESCALE (MIN_PRESCALE)
    ) u_cfg_shadow (
        .clk        (clk),
        .rst        (rst),
        .i_en       (bus.en),
        .i_prescale (bus.prescale),
        .i_data_len (bus.data_len),
        .i_par_en   (bus.par_en),
        .i_stop2    (bus.stop2),
        .o_prescale (w_s_prescale),
        .o_data_len (w_s_data_len),
        .o_par_en   (w_s_par_en),
        .o_stop2    (w_s_stop2),
        .o_cfg_err  (w_cfg_err)
    );

    assign w_run        = bus.en & ~w_cfg_err;
    assign w_mid        = w_s_prescale >> 1;
    assign w_frame_last = BIT_CNT_W'(frame_bits(w_s_data_len, w_s_par_en, w_s_stop2) - 1);
    assign w_edge_last  = (r_edge_cnt == w_s_prescale);
    assign w_bit_last   = (r_bit_cnt == w_frame_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_cnt <= PRESCALE_W'(1);
            r_bit_cnt  <= '0;
        end else if (!bus.en) begin
            r_edge_cnt <= PRESCALE_W'(1);
            r_bit_cnt  <= '0;
        end else if (!w_cfg_err) begin
            if (w_edge_last) begin
                r_edge_cnt <= PRESCALE_W'(1);
                r_bit_cnt  <= w_bit_last ? '0 : r_bit_cnt + BIT_CNT_W'(1);
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end
        end
    end

    // With prescale >= MIN_PRESCALE the mid-1..mid+1 window never reaches the last edge.
    assign bus.sample_stb  = w_run & ((r_edge_cnt == w_mid - PRESCALE_W'(1))
                                    | (r_edge_cnt == w_mid)
                                    | (r_edge_cnt == w_mid + PRESCALE_W'(1)));
    assign bus.sample_last = w_run & (r_edge_cnt == w_mid + PRESCALE_W'(1));
    assign bus.bit_done    = w_run & w_edge_last;
    assign bus.frame_done  = w_run & w_edge_last & w_bit_last;

    assign bus.edge_cnt    = r_edge_cnt;
    assign bus.bit_cnt     = r_bit_cnt;
    assign bus.cfg_err     = w_cfg_err;

endmodule
